dec_word_parser: RTL and testbench

Converts an ASCII byte stream of signed decimal numbers into 12-bit two's-complement words and writes them into the Hovalaag input FIFO. It sits directly upstream of the FIFO: bytes come from the UART receiver, and `word_valid`/`word_data` drive the FIFO's `data_write`/`data_in`. One number becomes one write, emitted when its terminating separator arrives.

---
 rtl/hovalaag_pkg.sv | 36 +++
 rtl/char_classify.sv | 25 ++
 rtl/dec_word_parser.sv | 183 ++++++++++++++++++
 tb/tb_dec_word_parser.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hovalaag_pkg.sv
// Shared definitions for the Hovalaag input path: word width, byte classes,
// parser states and the ASCII bytes the parser cares about.
package hovalaag_pkg;

   localparam int WORD_W = 12;

   typedef enum logic [1:0] {
      DIGIT = 2'd0,
      MINUS = 2'd1,
      SEP   = 2'd2,
      OTHER = 2'd3
   } byte_class_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SIGN   = 2'd1,
      DIGITS = 2'd2,
      SKIP   = 2'd3
   } parse_state_e;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_COMMA = 8'h2C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_TAB   = 8'h09;

   // True for any byte that terminates a number.
   function automatic logic is_separator(input logic [7:0] b);
      return (b == ASCII_SPACE) || (b == ASCII_COMMA) || (b == ASCII_CR) ||
             (b == ASCII_LF)    || (b == ASCII_TAB);
   endfunction

endpackage

// File: rtl/char_classify.sv
// Combinational byte classifier: maps an ASCII byte to its class and, for
// digits, its numeric value. Shared with the output formatter.
module char_classify
   import hovalaag_pkg::*;
(
   input  logic [7:0]  rx_byte,
   output byte_class_e byte_class,
   output logic [3:0]  digit
);

   // Classify the byte; digit value is zero for anything that is not a digit.
   always_comb begin
      byte_class = OTHER;
      digit      = 4'd0;
      if ((rx_byte >= ASCII_ZERO) && (rx_byte <= ASCII_NINE)) begin
         byte_class = DIGIT;
         digit      = rx_byte[3:0];
      end else if (rx_byte == ASCII_MINUS) begin
         byte_class = MINUS;
      end else if (is_separator(rx_byte)) begin
         byte_class = SEP;
      end
   end

endmodule

// File: rtl/dec_word_parser.sv
// ASCII signed-decimal to 12-bit two's-complement word parser feeding the
// Hovalaag input FIFO. One word is written per number, on its separator.
// Build option: define DEC_WORD_PARSER_SAT_EN for a saturating accumulator
// and clamped output; otherwise values wrap modulo 4096.
module dec_word_parser
   import hovalaag_pkg::*;
#(
   parameter int COUNT_W = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic               word_valid,
   output logic [WORD_W-1:0]  word_data,
   output logic               parse_err,
   output logic [COUNT_W-1:0] word_count
);

`ifdef DEC_WORD_PARSER_SAT_EN
   localparam int ACC_W = 13;
`else
   localparam int ACC_W = 12;
`endif

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_SIGN   = SIGN;
   localparam logic [1:0] ST_DIGITS = DIGITS;
   localparam logic [1:0] ST_SKIP   = SKIP;

   byte_class_e        rx_class;
   logic [3:0]         rx_digit;

   logic [1:0]         state_reg, state_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic               neg_reg, neg_next;
   logic [ACC_W-1:0]   acc_step;
   logic [WORD_W-1:0]  emit_value;
   logic               emit_next;
   logic               err_next;

   logic               word_valid_reg;
   logic [WORD_W-1:0]  word_data_reg;
   logic               parse_err_reg;
   logic [COUNT_W-1:0] word_count_reg;

   char_classify u_classify (
      .rx_byte    (rx_data),
      .byte_class (rx_class),
      .digit      (rx_digit)
   );

`ifdef DEC_WORD_PARSER_SAT_EN
   logic [ACC_W+3:0] acc_wide;

   // acc*10 + d computed wide, then pinned at 4096 so overflow is sticky.
   always_comb begin
      acc_wide = ({4'd0, acc_reg} << 3) + ({4'd0, acc_reg} << 1) +
                 {{ACC_W{1'b0}}, rx_digit};
      acc_step = (acc_wide >= (ACC_W+4)'(4096)) ? ACC_W'(4096) : acc_wide[ACC_W-1:0];
   end

   // Signed value clamped into the 12-bit two's-complement range.
   always_comb begin
      if (neg_reg) begin
         emit_value = (acc_reg >= ACC_W'(2048)) ? 12'h800 : WORD_W'(ACC_W'(0) - acc_reg);
      end else begin
         emit_value = (acc_reg >= ACC_W'(2047)) ? 12'h7FF : acc_reg[WORD_W-1:0];
      end
   end
`else
   // acc*10 + d in 12 bits, so the accumulator wraps modulo 4096.
   always_comb begin
      acc_step = (acc_reg << 3) + (acc_reg << 1) + ACC_W'(rx_digit);
   end

   // Signed value reduced modulo 4096, no clamping.
   always_comb begin
      emit_value = neg_reg ? (WORD_W'(0) - acc_reg) : acc_reg;
   end
`endif

   // Parser FSM: every transition happens only on an accepted byte.
   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      neg_next   = neg_reg;
      emit_next  = 1'b0;
      err_next   = 1'b0;
      if (rx_valid) begin
         case (state_reg)
            ST_IDLE: begin
               case (rx_class)
                  DIGIT: begin
                     state_next = ST_DIGITS;
                     acc_next   = ACC_W'(rx_digit);
                     neg_next   = 1'b0;
                  end
                  MINUS:   state_next = ST_SIGN;
                  SEP:     state_next = ST_IDLE;
                  default: begin
                     state_next = ST_SKIP;
                     err_next   = 1'b1;
                  end
               endcase
            end
            ST_SIGN: begin
               case (rx_class)
                  DIGIT: begin
                     state_next = ST_DIGITS;
                     acc_next   = ACC_W'(rx_digit);
                     neg_next   = 1'b1;
                  end
                  SEP: begin
                     // A lone minus is malformed and produces no word.
                     state_next = ST_IDLE;
                     err_next   = 1'b1;
                  end
                  default: begin
                     state_next = ST_SKIP;
                     err_next   = 1'b1;
                  end
               endcase
            end
            ST_DIGITS: begin
               case (rx_class)
                  DIGIT:   acc_next = acc_step;
                  SEP: begin
                     state_next = ST_IDLE;
                     emit_next  = 1'b1;
                  end
                  default: begin
                     // Partial number is dropped; SKIP runs to the next separator.
                     state_next = ST_SKIP;
                     err_next   = 1'b1;
                  end
               endcase
            end
            default: begin
               if (rx_class == SEP) begin
                  state_next = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Parser state registers; reset discards any partial number.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         acc_reg   <= '0;
         neg_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         neg_reg   <= neg_next;
      end
   end

   // Registered FIFO write strobe, held data, error pulse and word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_valid_reg <= 1'b0;
         word_data_reg  <= '0;
         parse_err_reg  <= 1'b0;
         word_count_reg <= '0;
      end else begin
         word_valid_reg <= emit_next;
         parse_err_reg  <= err_next;
         if (emit_next) begin
            word_data_reg  <= emit_value;
            word_count_reg <= word_count_reg + COUNT_W'(1);
         end
      end
   end

   assign word_valid = word_valid_reg;
   assign word_data  = word_data_reg;
   assign parse_err  = parse_err_reg;
   assign word_count = word_count_reg;

endmodule

// File: tb/tb_dec_word_parser.sv
// Directed testbench for dec_word_parser: feeds ASCII strings and checks the
// emitted words, error pulses, word counter and strobe timing.
module tb_dec_word_parser;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        word_valid;
   logic [11:0] word_data;
   logic        parse_err;
   logic [12:0] word_count;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          exp_count = 0;
   int          last_cyc = 0;
   int          perr = 0;
   logic [11:0] wq[$];
   int          cq[$];

   dec_word_parser #(.COUNT_W(13)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .word_valid (word_valid),
      .word_data  (word_data),
      .parse_err  (parse_err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture strobes and error pulses on the falling edge.
   always @(negedge clk) begin
      if (word_valid) begin
         wq.push_back(word_data);
         cq.push_back(cyc);
      end
      if (parse_err) perr++;
   end

   task automatic clear_capture();
      wq.delete();
      cq.delete();
      perr = 0;
   endtask

   // Drive a string one byte per cycle, with 'gap' idle cycles after each byte.
   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = s[i];
         last_cyc = cyc + 1;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %0b want 0", word_valid); end
      checks++; if (word_data !== 12'h000) begin errors++; $display("FAIL reset_word_data got %h want 000", word_data); end
      checks++; if (parse_err !== 1'b0) begin errors++; $display("FAIL reset_parse_err got %0b want 0", parse_err); end
      checks++; if (word_count !== 13'd0) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      clear_capture();
      send_str("12,-7\n", 0);
      exp_count += 2;
      checks++;
      if (wq.size() != 2) begin
         errors++; $display("FAIL basic_nwords got %0d want 2", wq.size());
      end else begin
         checks++; if (wq[0] !== 12'h00C) begin errors++; $display("FAIL basic_w0 got %h want 00C", wq[0]); end
         checks++; if (wq[1] !== 12'hFF9) begin errors++; $display("FAIL basic_w1 got %h want FF9", wq[1]); end
      end
      checks++; if (word_count !== 13'(exp_count)) begin errors++; $display("FAIL basic_count got %0d want %0d", word_count, exp_count); end
      checks++; if (perr != 0) begin errors++; $display("FAIL basic_perr got %0d want 0", perr); end
      $display("test_basic \"12,-7\" words=%0d count=%0d", wq.size(), word_count);
   endtask

   task automatic test_range();
      logic [11:0] e_pos, e_neg;
`ifdef DEC_WORD_PARSER_SAT_EN
      e_pos = 12'h7FF; e_neg = 12'h800;
`else
      e_pos = 12'h388; e_neg = 12'hC78;
`endif
      clear_capture();
      send_str("2047 -2048 ", 0);
      exp_count += 2;
      checks++;
      if (wq.size() != 2) begin
         errors++; $display("FAIL edge_nwords got %0d want 2", wq.size());
      end else begin
         checks++; if (wq[0] !== 12'h7FF) begin errors++; $display("FAIL edge_2047 got %h want 7FF", wq[0]); end
         checks++; if (wq[1] !== 12'h800) begin errors++; $display("FAIL edge_m2048 got %h want 800", wq[1]); end
      end
      clear_capture();
      send_str("5000 -5000 ", 0);
      exp_count += 2;
      checks++;
      if (wq.size() != 2) begin
         errors++; $display("FAIL big_nwords got %0d want 2", wq.size());
      end else begin
         checks++; if (wq[0] !== e_pos) begin errors++; $display("FAIL big_5000 got %h want %h", wq[0], e_pos); end
         checks++; if (wq[1] !== e_neg) begin errors++; $display("FAIL big_m5000 got %h want %h", wq[1], e_neg); end
      end
      checks++; if (word_count !== 13'(exp_count)) begin errors++; $display("FAIL range_count got %0d want %0d", word_count, exp_count); end
      $display("test_range done count=%0d", word_count);
   endtask

   task automatic test_errors();
      clear_capture();
      send_str("1x3 4 ", 0);
      exp_count += 1;
      checks++; if (perr != 1) begin errors++; $display("FAIL err_x_perr got %0d want 1", perr); end
      checks++;
      if (wq.size() != 1) begin
         errors++; $display("FAIL err_x_nwords got %0d want 1", wq.size());
      end else begin
         checks++; if (wq[0] !== 12'h004) begin errors++; $display("FAIL err_x_word got %h want 004", wq[0]); end
      end
      clear_capture();
      send_str("- ,,  \n", 0);
      checks++; if (perr != 1) begin errors++; $display("FAIL lone_minus_perr got %0d want 1", perr); end
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL lone_minus_nwords got %0d want 0", wq.size()); end
      clear_capture();
      send_str("-0 007 ", 0);
      exp_count += 2;
      checks++;
      if (wq.size() != 2) begin
         errors++; $display("FAIL zero_nwords got %0d want 2", wq.size());
      end else begin
         checks++; if (wq[0] !== 12'h000) begin errors++; $display("FAIL neg_zero got %h want 000", wq[0]); end
         checks++; if (wq[1] !== 12'h007) begin errors++; $display("FAIL lead_zero got %h want 007", wq[1]); end
      end
      checks++; if (word_count !== 13'(exp_count)) begin errors++; $display("FAIL errors_count got %0d want %0d", word_count, exp_count); end
      $display("test_errors done count=%0d", word_count);
   endtask

   task automatic test_back_to_back();
      clear_capture();
      send_str("1 2 ", 0);
      exp_count += 2;
      checks++;
      if (wq.size() != 2) begin
         errors++; $display("FAIL b2b_nwords got %0d want 2", wq.size());
      end else begin
         checks++; if (wq[0] !== 12'h001) begin errors++; $display("FAIL b2b_w0 got %h want 001", wq[0]); end
         checks++; if (wq[1] !== 12'h002) begin errors++; $display("FAIL b2b_w1 got %h want 002", wq[1]); end
         checks++; if (cq[1] - cq[0] != 2) begin errors++; $display("FAIL b2b_spacing got %0d want 2", cq[1] - cq[0]); end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      clear_capture();
      send_str("12", 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      clear_capture();
      send_str(" 3 ", 0);
      exp_count += 1;
      checks++;
      if (wq.size() != 1) begin
         errors++; $display("FAIL rstmid_nwords got %0d want 1", wq.size());
      end else begin
         checks++; if (wq[0] !== 12'h003) begin errors++; $display("FAIL rstmid_word got %h want 003", wq[0]); end
      end
      checks++; if (word_count !== 13'(exp_count)) begin errors++; $display("FAIL rstmid_count got %0d want %0d", word_count, exp_count); end
      $display("test_reset_mid done count=%0d", word_count);
   endtask

   task automatic test_gaps();
      clear_capture();
      send_str("45 ", 3);
      exp_count += 1;
      checks++;
      if (wq.size() != 1) begin
         errors++; $display("FAIL gap_nwords got %0d want 1", wq.size());
      end else begin
         checks++; if (wq[0] !== 12'h02D) begin errors++; $display("FAIL gap_word got %h want 02D", wq[0]); end
         checks++; if (cq[0] != last_cyc) begin errors++; $display("FAIL gap_latency got cycle %0d want %0d", cq[0], last_cyc); end
      end
      repeat (4) @(negedge clk);
      checks++; if (word_data !== 12'h02D) begin errors++; $display("FAIL gap_hold got %h want 02D", word_data); end
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL gap_idle_valid got %0b want 0", word_valid); end
      checks++; if (word_count !== 13'(exp_count)) begin errors++; $display("FAIL gap_count got %0d want %0d", word_count, exp_count); end
      $display("test_gaps done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_range();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_gaps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
